axis_packet_arbiter: RTL and testbench

Packet-level arbiter that shares one downstream AXI-stream datapath (the header-insert/skid-buffer chain) between NUM_SRC upstream packet sources. Grants one source at a time, holds the grant until that source's last beat handshakes, forwards beats through a single output register stage, and tags each output beat with the source index. Sits directly in front of the header-insert datapath.

---
 rtl/axis_arb_pkg.sv | 25 ++
 rtl/rr_select.sv | 49 ++++
 rtl/axis_packet_arbiter.sv | 147 ++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
//============================================================================
// Module      : axis_arb_pkg
// Description : Shared state encoding, source-count limit and index-width
//               helper for the AXI-stream packet arbiter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package axis_arb_pkg;

    localparam int MAX_SRC = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // A single requester still needs a one-bit index so ports never collapse.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_select.sv
//============================================================================
// Module      : rr_select
// Description : Combinational winner select. Round-robin from a pointer by
//               default; lowest-index-wins when ARB_FIXED_PRIORITY_EN is set.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module rr_select
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int SRC_W   = src_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
`ifndef ARB_FIXED_PRIORITY_EN
    input  logic [SRC_W-1:0]   ptr,
`endif
    output logic               any,
    output logic [SRC_W-1:0]   winner
);

    assign any = |req;

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[SRC_W'(i)]) winner = SRC_W'(i);
        end
    end
`else
    logic [SRC_W-1:0] w_idx;

    // Scan offsets high to low so the nearest request at/after ptr wins last.
    always_comb begin
        winner = '0;
        w_idx  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (int'(ptr) + k >= NUM_SRC) w_idx = SRC_W'(int'(ptr) + k - NUM_SRC);
            else                          w_idx = SRC_W'(int'(ptr) + k);
            if (req[w_idx]) winner = w_idx;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
//============================================================================
// Module      : axis_packet_arbiter
// Description : Packet-level AXI-stream arbiter with one output register
//               stage and source tagging. ARB_FIXED_PRIORITY_EN selects
//               fixed priority instead of round-robin.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int SRC_W      = src_width(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            s_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0] s_keep,
    input  logic [NUM_SRC-1:0]            s_last,
    output logic [NUM_SRC-1:0]            s_ready,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [KEEP_WIDTH-1:0]         m_keep,
    output logic                          m_last,
    output logic [SRC_W-1:0]              m_src,
    input  logic                          m_ready,
    output logic                          busy
);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [SRC_W-1:0]        r_grant;
    logic                    w_any;
    logic [SRC_W-1:0]        w_winner;
    logic                    w_out_free;
    logic                    w_take;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [KEEP_WIDTH-1:0]   w_sel_keep;

    logic                    r_m_valid;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic [KEEP_WIDTH-1:0]   r_m_keep;
    logic                    r_m_last;
    logic [SRC_W-1:0]        r_m_src;

`ifndef ARB_FIXED_PRIORITY_EN
    logic [SRC_W-1:0]        r_ptr;
`endif

    rr_select #(
        .NUM_SRC (NUM_SRC)
    ) u_select (
        .req    (s_valid),
`ifndef ARB_FIXED_PRIORITY_EN
        .ptr    (r_ptr),
`endif
        .any    (w_any),
        .winner (w_winner)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == SRC_W'(i)) begin
                w_sel_valid = s_valid[i];
                w_sel_last  = s_last[i];
                w_sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_keep  = s_keep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    // Output stage can accept whenever empty or draining this cycle.
    assign w_out_free = !r_m_valid || m_ready;
    assign w_take     = (r_state == BUSY) && w_out_free && w_sel_valid;

    always_comb begin
        s_ready = '0;
        if ((r_state == BUSY) && w_out_free) s_ready = NUM_SRC'(1) << r_grant;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = BUSY;
            BUSY:    if (w_take && w_sel_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_any) r_grant <= w_winner;
        end
    end

`ifndef ARB_FIXED_PRIORITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_take && w_sel_last) begin
            r_ptr <= (r_grant == SRC_W'(NUM_SRC - 1)) ? '0 : r_grant + SRC_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_src   <= '0;
        end else if (w_take) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_sel_data;
            r_m_keep  <= w_sel_keep;
            r_m_last  <= w_sel_last;
            r_m_src   <= r_grant;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_keep  = r_m_keep;
    assign m_last  = r_m_last;
    assign m_src   = r_m_src;
    assign busy    = (r_state == BUSY);

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
//============================================================================
// Module      : tb_axis_packet_arbiter
// Description : Randomized scoreboard bench for axis_packet_arbiter with a
//               packet-level reference model of grant order and handshakes.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_packet_arbiter;

    localparam int NUM_SRC    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int KEEP_WIDTH = 4;
    localparam int SRC_W      = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  src;
    } beat_t;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [NUM_SRC-1:0]            s_valid = '0;
    logic [NUM_SRC*DATA_WIDTH-1:0] s_data = '0;
    logic [NUM_SRC*KEEP_WIDTH-1:0] s_keep = '0;
    logic [NUM_SRC-1:0]            s_last = '0;
    logic [NUM_SRC-1:0]            s_ready;
    logic                          m_valid;
    logic [DATA_WIDTH-1:0]         m_data;
    logic [KEEP_WIDTH-1:0]         m_keep;
    logic                          m_last;
    logic [SRC_W-1:0]              m_src;
    logic                          m_ready = 1'b1;
    logic                          busy;

    axis_packet_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last),
        .m_src   (m_src),
        .m_ready (m_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    beat_t              srcq [NUM_SRC][$];
    beat_t              sb [$];
    logic [NUM_SRC-1:0] hold = '0;
    int                 rdy_pct = 100;
    int                 checks = 0;
    int                 errors = 0;

    // Reference model: packet-level arbiter state.
    bit mdl_busy = 0;
    int mdl_grant = 0;
    int mdl_ptr = 0;
    bit mdl_mv = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NUM_SRC-1:0] v, input int ptr);
        int p;
        p = ptr;
`ifdef ARB_FIXED_PRIORITY_EN
        p = 0;
`endif
        for (int k = 0; k < NUM_SRC; k++)
            if (v[(p + k) % NUM_SRC]) return (p + k) % NUM_SRC;
        return 0;
    endfunction

    task automatic push_pkt(input int s, input int len, input bit seq, input logic [31:0] base);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = seq ? base + 32'(j) : $urandom;
            b.keep = seq ? 4'hF : 4'($urandom_range(15));
            b.last = (j == len - 1);
            b.src  = 2'(s);
            srcq[s].push_back(b);
        end
    endtask

    task automatic cycle();
        logic [NUM_SRC-1:0] v;
        logic [NUM_SRC-1:0] exp_rdy;
        bit    was_busy;
        bit    take;
        beat_t b;
        @(negedge clk);
        m_ready = ($urandom_range(99) < rdy_pct);
        v = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (srcq[i].size() > 0) begin
                v[i] = !hold[i];
                s_data[i*DATA_WIDTH +: DATA_WIDTH] = srcq[i][0].data;
                s_keep[i*KEEP_WIDTH +: KEEP_WIDTH] = srcq[i][0].keep;
                s_last[i] = srcq[i][0].last;
            end else begin
                s_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                s_keep[i*KEEP_WIDTH +: KEEP_WIDTH] = '0;
                s_last[i] = 1'b0;
            end
        end
        s_valid = v;
        #1;
        exp_rdy = (mdl_busy && (!mdl_mv || m_ready)) ? (4'b0001 << mdl_grant) : 4'b0000;
        chk("s_ready", 64'(s_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(mdl_busy));
        chk("m_valid", 64'(m_valid), 64'(mdl_mv));
        was_busy = mdl_busy;
        take = mdl_busy && (!mdl_mv || m_ready) && v[mdl_grant];
        if (take) begin
            b = srcq[mdl_grant].pop_front();
            sb.push_back(b);
            mdl_mv = 1;
            if (b.last) begin
                mdl_busy = 0;
                mdl_ptr  = (mdl_grant + 1) % NUM_SRC;
            end
        end else if (m_ready) begin
            mdl_mv = 0;
        end
        if (!was_busy && (v != '0)) begin
            mdl_busy  = 1;
            mdl_grant = pick(v, mdl_ptr);
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = '0;
        m_ready = 1'b1;
        hold    = '0;
        for (int i = 0; i < NUM_SRC; i++) srcq[i].delete();
        @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_keep", 64'(m_keep), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_src", 64'(m_src), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        sb.delete();
        mdl_busy = 0; mdl_grant = 0; mdl_ptr = 0; mdl_mv = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_SRC; i++) if (srcq[i].size() > 0) return 1;
        return (sb.size() > 0) || mdl_mv || mdl_busy;
    endfunction

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h src %0d expected none", m_data, m_src);
                end else begin
                    e = sb.pop_front();
                    chk("m_data", 64'(m_data), 64'(e.data));
                    chk("m_keep", 64'(m_keep), 64'(e.keep));
                    chk("m_last", 64'(m_last), 64'(e.last));
                    chk("m_src", 64'(m_src), 64'(e.src));
                end
            end
        end
    end

    initial begin
        do_reset();

        // Single source, sequential payload.
        rdy_pct = 100;
        push_pkt(1, 3, 1, 32'hA0);
        run(8);

        // Contention from reset: src0 then src2, then src3 ahead of src0.
        do_reset();
        push_pkt(0, 2, 1, 32'h100);
        push_pkt(2, 2, 1, 32'h200);
        run(10);
        push_pkt(0, 1, 1, 32'h300);
        push_pkt(3, 1, 1, 32'h400);
        run(8);

        // All sources continuously requesting single-beat packets.
        for (int i = 0; i < NUM_SRC; i++)
            for (int j = 0; j < 3; j++) push_pkt(i, 1, 1, 32'h1000 + 32'(i*16 + j));
        run(30);

        // Backpressure on an 8-beat packet.
        rdy_pct = 50;
        push_pkt(2, 8, 0, 32'h0);
        run(40);
        rdy_pct = 100;
        run(4);

        // Mid-packet bubble on granted src3 while src0 waits.
        push_pkt(3, 4, 1, 32'h3300);
        run(3);
        hold[3] = 1'b1;
        push_pkt(0, 2, 1, 32'h0500);
        run(2);
        hold[3] = 1'b0;
        run(12);

        // Reset mid-packet, then arbitration restarts from source 0.
        push_pkt(1, 4, 1, 32'h1100);
        run(3);
        do_reset();
        push_pkt(3, 1, 1, 32'h7300);
        push_pkt(0, 1, 1, 32'h7000);
        run(8);

        // Randomized traffic with random bubbles and backpressure.
        rdy_pct = 70;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(99) < 10) begin
                int s;
                s = $urandom_range(NUM_SRC - 1);
                if (srcq[s].size() < 10) push_pkt(s, $urandom_range(6, 1), 0, 32'h0);
            end
            for (int i = 0; i < NUM_SRC; i++) hold[i] = ($urandom_range(9) == 0);
            cycle();
        end

        // Drain with bounded budget.
        hold = '0;
        rdy_pct = 100;
        for (int c = 0; c < 400 && pending(); c++) cycle();
        run(2);
        chk("drain_scoreboard", 64'(sb.size()), 64'd0);
        chk("drain_model_idle", 64'(mdl_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
